// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg
// Shared definitions for the instruction-memory program loader:
// FSM state encodings, frame layout constants and the memory base address.
package imem_loader_pkg;

    localparam int LEN_BYTES  = 2;
    localparam int WORD_BYTES = 4;

    // Byte address where the instruction memory is mapped in the CPU space.
    localparam logic [31:0] IMEM_BASE = 32'h0040_0000;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_LEN_HI = 3'd1;
    localparam state_t ST_LEN_LO = 3'd2;
    localparam state_t ST_DATA   = 3'd3;
    localparam state_t ST_WRITE  = 3'd4;
    localparam state_t ST_CSUM   = 3'd5;
    localparam state_t ST_DONE   = 3'd6;
    localparam state_t ST_ERROR  = 3'd7;

    function automatic logic accepts_bytes(input state_t s);
        return (s == ST_LEN_HI) || (s == ST_LEN_LO) || (s == ST_DATA) || (s == ST_CSUM);
    endfunction

    function automatic logic is_quiescent(input state_t s);
        return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_ERROR);
    endfunction

endpackage

// File: rtl/imem_loader_word_assembler.sv
// imem_loader_word_assembler
// Shifts payload bytes into a big-endian 32-bit word, counts bytes within
// the word and keeps a running XOR checksum of every byte shifted in.
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   clear       restart for a new frame (word, counter, checksum to zero)
//   shift_en    accept byte_in this cycle
//   byte_in     payload byte
//   word        assembled word (first byte of a word ends up in [31:24])
//   csum        XOR of all bytes shifted since the last clear
//   word_last   shift_en on the final byte of a word
module imem_loader_word_assembler
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        shift_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic [7:0]  csum,
    output logic        word_last
);

    logic [1:0] byte_cnt;

    assign word_last = shift_en && (byte_cnt == 2'(WORD_BYTES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            word     <= '0;
            csum     <= '0;
            byte_cnt <= '0;
        end else if (clear) begin
            word     <= '0;
            csum     <= '0;
            byte_cnt <= '0;
        end else if (shift_en) begin
            word     <= {word[23:0], byte_in};
            csum     <= csum ^ byte_in;
            byte_cnt <= byte_cnt + 2'd1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// imem_loader
// Program-load initiator for the instruction memory init port. Receives a
// framed byte stream (2-byte big-endian word count, 4*N payload bytes,
// 1-byte XOR checksum) and writes one big-endian word per WRITE cycle.
// Ports:
//   clk, rst           clock and synchronous active-high reset
//   start              pulse to begin a load (ignored while busy)
//   byte_in/valid      stream input; byte_ready is the handshake return
//   init_mode          high for the whole load, feeds memory init_mode
//   init_address       word index of the current write
//   init_instruction   word being written
//   write_enable       one-cycle write strobe
//   busy/done/error    load status; done and error are sticky until start
//   words_loaded       words written in the current or last load
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | after reset, waiting for start
// LEN_HI  | waiting for word-count high byte
// LEN_LO  | waiting for word-count low byte, then range check
// DATA    | collecting payload bytes of the current word
// WRITE   | single-cycle write strobe to the memory
// CSUM    | waiting for the checksum byte
// DONE    | load finished with good checksum
// ERROR   | bad length or checksum mismatch
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W    = 12,
    parameter int MAX_WORDS = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              init_mode,
    output logic [ADDR_W-1:0] init_address,
    output logic [31:0]       init_instruction,
    output logic              write_enable,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    state_t          state;
    logic [7:0]      len_hi;
    logic [ADDR_W:0] len_words;
    logic            xfer;
    logic [31:0]     n_full;
    logic            len_bad;
    logic [ADDR_W:0] wl_next;
    logic            asm_clear;
    logic            asm_shift;
    logic            word_last;
    logic [31:0]     word;
    logic [7:0]      csum;

    assign byte_ready = accepts_bytes(state);
    assign xfer       = byte_valid && byte_ready;

    // Widened so the range check works for any ADDR_W; once validated the
    // count always fits in ADDR_W+1 bits because MAX_WORDS <= 2**ADDR_W.
    assign n_full  = {16'h0000, len_hi, byte_in};
    assign len_bad = (n_full == 32'd0) || (n_full > 32'(MAX_WORDS));
    assign wl_next = words_loaded + (ADDR_W + 1)'(1);

    assign asm_clear = is_quiescent(state) && start;
    assign asm_shift = (state == ST_DATA) && xfer;

    imem_loader_word_assembler u_asm (
        .clk       (clk),
        .rst       (rst),
        .clear     (asm_clear),
        .shift_en  (asm_shift),
        .byte_in   (byte_in),
        .word      (word),
        .csum      (csum),
        .word_last (word_last)
    );

    assign busy             = !is_quiescent(state);
    assign init_mode        = busy;
    assign write_enable     = (state == ST_WRITE);
    assign init_address     = words_loaded[ADDR_W-1:0];
    assign init_instruction = word;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            len_hi       <= '0;
            len_words    <= '0;
            words_loaded <= '0;
            done         <= 1'b0;
            error        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start) begin
                        state        <= ST_LEN_HI;
                        done         <= 1'b0;
                        error        <= 1'b0;
                        words_loaded <= '0;
                    end
                end
                ST_LEN_HI: begin
                    if (xfer) begin
                        len_hi <= byte_in;
                        state  <= ST_LEN_LO;
                    end
                end
                ST_LEN_LO: begin
                    if (xfer) begin
                        if (len_bad) begin
                            state <= ST_ERROR;
                            error <= 1'b1;
                        end else begin
                            len_words <= n_full[ADDR_W:0];
                            state     <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (word_last) begin
                        state <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    words_loaded <= wl_next;
                    state        <= (wl_next == len_words) ? ST_CSUM : ST_DATA;
                end
                ST_CSUM: begin
                    if (xfer) begin
                        if (byte_in == csum) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_ERROR;
                            error <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

    localparam int ADDR_W = 12;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              init_mode;
    logic [ADDR_W-1:0] init_address;
    logic [31:0]       init_instruction;
    logic              write_enable;
    logic              busy;
    logic              done;
    logic              error;
    logic [ADDR_W:0]   words_loaded;

    int checks = 0;
    int errors = 0;

    logic [ADDR_W-1:0] wr_addr[$];
    logic [31:0]       wr_data[$];
    int                ready_viol = 0;
    logic [31:0]       fw[0:7];

    imem_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(4096)) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .byte_in          (byte_in),
        .byte_valid       (byte_valid),
        .byte_ready       (byte_ready),
        .init_mode        (init_mode),
        .init_address     (init_address),
        .init_instruction (init_instruction),
        .write_enable     (write_enable),
        .busy             (busy),
        .done             (done),
        .error            (error),
        .words_loaded     (words_loaded)
    );

    always #5 clk = ~clk;

    // Write log, sampled mid-cycle.
    always @(negedge clk) begin
        if (write_enable === 1'b1) begin
            wr_addr.push_back(init_address);
            wr_data.push_back(init_instruction);
            if (byte_ready !== 1'b0) ready_viol++;
        end
    end

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        ready_viol = 0;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit rnd);
        int  t;
        bit  got;
        if (rnd) begin
            for (int g = 0; g < 6; g++) begin
                if ($urandom_range(0, 1) == 0) break;
                byte_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        byte_in    = b;
        byte_valid = 1'b1;
        t   = 0;
        got = 1'b0;
        while (!got && t < 200) begin
            @(negedge clk);
            if (byte_ready === 1'b1) got = 1'b1;
            t++;
        end
        if (!got) begin
            errors++;
            $display("FAIL send_byte_timeout: byte_ready=%b required 1", byte_ready);
        end
        @(posedge clk); #1;
        byte_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [15:0] n, input logic [7:0] cs, input bit rnd);
        logic [31:0] w;
        send_byte(n[15:8], rnd);
        send_byte(n[7:0], rnd);
        for (int i = 0; i < int'(n); i++) begin
            w = fw[i];
            for (int k = 0; k < 4; k++) send_byte(w[31-8*k -: 8], rnd);
        end
        send_byte(cs, rnd);
    endtask

    task automatic wait_not_busy();
        int t;
        t = 0;
        while (busy === 1'b1 && t < 300) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL wait_not_busy: busy=%b required 0", busy);
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({byte_ready, init_mode, init_address, init_instruction, write_enable,
             busy, done, error, words_loaded} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: rdy=%b im=%b addr=%h instr=%h we=%b busy=%b done=%b err=%b wl=%0d required all 0",
                     byte_ready, init_mode, init_address, init_instruction, write_enable,
                     busy, done, error, words_loaded);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (byte_ready !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: rdy=%b busy=%b required 0 0", byte_ready, busy);
        end
    endtask

    task automatic test_good_load();
        clear_log();
        fw[0] = 32'h2008_0005;
        fw[1] = 32'h0000_000C;
        pulse_start();
        send_byte(8'h00, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h20, 1'b0);
        send_byte(8'h08, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h05, 1'b0);
        // Cycle right after the 4th byte's transfer edge.
        checks++;
        if (write_enable !== 1'b1 || init_address !== 12'd0 ||
            init_instruction !== 32'h2008_0005 || byte_ready !== 1'b0) begin
            errors++;
            $display("FAIL good_write_latency: we=%b addr=%h instr=%h rdy=%b required 1 000 20080005 0",
                     write_enable, init_address, init_instruction, byte_ready);
        end
        for (int k = 0; k < 4; k++) send_byte(fw[1][31-8*k -: 8], 1'b0);
        send_byte(8'h21, 1'b0);
        checks++;
        if (done !== 1'b1 || init_mode !== 1'b0 || error !== 1'b0) begin
            errors++;
            $display("FAIL good_done_edge: done=%b init_mode=%b err=%b required 1 0 0",
                     done, init_mode, error);
        end
        wait_not_busy();
        checks++;
        if (wr_addr.size() != 2) begin
            errors++;
            $display("FAIL good_write_count: got %0d required 2", wr_addr.size());
        end else begin
            checks++;
            if (wr_addr[0] !== 12'd0 || wr_data[0] !== 32'h2008_0005 ||
                wr_addr[1] !== 12'd1 || wr_data[1] !== 32'h0000_000C) begin
                errors++;
                $display("FAIL good_writes: %h:%h %h:%h required 000:20080005 001:0000000c",
                         wr_addr[0], wr_data[0], wr_addr[1], wr_data[1]);
            end
        end
        checks++;
        if (words_loaded !== 13'd2 || busy !== 1'b0) begin
            errors++;
            $display("FAIL good_words_loaded: wl=%0d busy=%b required 2 0", words_loaded, busy);
        end
    endtask

    task automatic test_bad_csum();
        clear_log();
        fw[0] = 32'h2008_0005;
        fw[1] = 32'h0000_000C;
        pulse_start();
        send_frame(16'd2, 8'h00, 1'b0);
        wait_not_busy();
        checks++;
        if (error !== 1'b1 || done !== 1'b0 || words_loaded !== 13'd2) begin
            errors++;
            $display("FAIL bad_csum_status: err=%b done=%b wl=%0d required 1 0 2",
                     error, done, words_loaded);
        end
        checks++;
        if (wr_addr.size() != 2) begin
            errors++;
            $display("FAIL bad_csum_writes: got %0d required 2", wr_addr.size());
        end else begin
            checks++;
            if (wr_data[0] !== 32'h2008_0005 || wr_data[1] !== 32'h0000_000C) begin
                errors++;
                $display("FAIL bad_csum_data: %h %h required 20080005 0000000c", wr_data[0], wr_data[1]);
            end
        end
    endtask

    task automatic test_bad_len();
        logic [15:0] lens[2];
        lens[0] = 16'h0000;
        lens[1] = 16'h1001;
        for (int i = 0; i < 2; i++) begin
            clear_log();
            pulse_start();
            send_byte(lens[i][15:8], 1'b0);
            send_byte(lens[i][7:0], 1'b0);
            checks++;
            if (error !== 1'b1 || busy !== 1'b0 || byte_ready !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL bad_len_%h: err=%b busy=%b rdy=%b done=%b required 1 0 0 0",
                         lens[i], error, busy, byte_ready, done);
            end
            repeat (3) @(negedge clk);
            checks++;
            if (wr_addr.size() != 0) begin
                errors++;
                $display("FAIL bad_len_no_write_%h: got %0d writes required 0", lens[i], wr_addr.size());
            end
        end
        // 0x1000 is the largest legal count and must be accepted.
        pulse_start();
        send_byte(8'h10, 1'b0);
        send_byte(8'h00, 1'b0);
        checks++;
        if (error !== 1'b0 || busy !== 1'b1 || byte_ready !== 1'b1) begin
            errors++;
            $display("FAIL max_len_accept: err=%b busy=%b rdy=%b required 0 1 1", error, busy, byte_ready);
        end
        apply_reset();
    endtask

    task automatic test_random_valid();
        logic [31:0] exp[3];
        exp[0] = 32'h1122_3344;
        exp[1] = 32'hA5A5_A5A5;
        exp[2] = 32'h00FF_00FF;
        for (int i = 0; i < 3; i++) fw[i] = exp[i];
        for (int r = 0; r < 2; r++) begin
            clear_log();
            pulse_start();
            send_frame(16'd3, 8'h44, r == 1);
            wait_not_busy();
            checks++;
            if (done !== 1'b1 || error !== 1'b0 || words_loaded !== 13'd3) begin
                errors++;
                $display("FAIL n3_status_run%0d: done=%b err=%b wl=%0d required 1 0 3",
                         r, done, error, words_loaded);
            end
            checks++;
            if (wr_addr.size() != 3) begin
                errors++;
                $display("FAIL n3_count_run%0d: got %0d required 3", r, wr_addr.size());
            end else begin
                for (int i = 0; i < 3; i++) begin
                    checks++;
                    if (wr_addr[i] !== 12'(i) || wr_data[i] !== exp[i]) begin
                        errors++;
                        $display("FAIL n3_write_run%0d_%0d: %h:%h required %h:%h",
                                 r, i, wr_addr[i], wr_data[i], 12'(i), exp[i]);
                    end
                end
            end
            checks++;
            if (ready_viol != 0) begin
                errors++;
                $display("FAIL ready_in_write_run%0d: %0d cycles required 0", r, ready_viol);
            end
        end
    endtask

    task automatic test_reset_midload();
        clear_log();
        fw[0] = 32'h0102_0304;
        fw[1] = 32'h0506_0708;
        pulse_start();
        send_byte(8'h00, 1'b0);
        send_byte(8'h04, 1'b0);
        for (int k = 0; k < 4; k++) send_byte(fw[0][31-8*k -: 8], 1'b0);
        send_byte(8'h05, 1'b0);
        send_byte(8'h06, 1'b0);
        checks++;
        if (wr_addr.size() != 1) begin
            errors++;
            $display("FAIL midload_write_count: got %0d required 1", wr_addr.size());
        end else begin
            checks++;
            if (wr_addr[0] !== 12'd0 || wr_data[0] !== 32'h0102_0304) begin
                errors++;
                $display("FAIL midload_write: %h:%h required 000:01020304", wr_addr[0], wr_data[0]);
            end
        end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({byte_ready, init_mode, init_address, init_instruction, write_enable,
             busy, done, error, words_loaded} !== '0) begin
            errors++;
            $display("FAIL midload_reset_outputs: rdy=%b im=%b addr=%h instr=%h we=%b busy=%b done=%b err=%b wl=%0d required all 0",
                     byte_ready, init_mode, init_address, init_instruction, write_enable,
                     busy, done, error, words_loaded);
        end
        rst = 1'b0;
        clear_log();
        fw[0] = 32'hDEAD_BEEF;
        pulse_start();
        send_frame(16'd1, 8'h22, 1'b0);
        wait_not_busy();
        checks++;
        if (wr_addr.size() != 1 || done !== 1'b1 || words_loaded !== 13'd1) begin
            errors++;
            $display("FAIL reload_status: writes=%0d done=%b wl=%0d required 1 1 1",
                     wr_addr.size(), done, words_loaded);
        end else begin
            checks++;
            if (wr_addr[0] !== 12'd0 || wr_data[0] !== 32'hDEAD_BEEF) begin
                errors++;
                $display("FAIL reload_write: %h:%h required 000:deadbeef", wr_addr[0], wr_data[0]);
            end
        end
    endtask

    task automatic test_start_in_data();
        clear_log();
        fw[0] = 32'h2008_0005;
        fw[1] = 32'h0000_000C;
        pulse_start();
        send_byte(8'h00, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h20, 1'b0);
        send_byte(8'h08, 1'b0);
        pulse_start();
        checks++;
        if (busy !== 1'b1 || words_loaded !== 13'd0 || byte_ready !== 1'b1) begin
            errors++;
            $display("FAIL start_in_data_state: busy=%b wl=%0d rdy=%b required 1 0 1",
                     busy, words_loaded, byte_ready);
        end
        send_byte(8'h00, 1'b0);
        send_byte(8'h05, 1'b0);
        for (int k = 0; k < 4; k++) send_byte(fw[1][31-8*k -: 8], 1'b0);
        send_byte(8'h21, 1'b0);
        wait_not_busy();
        checks++;
        if (done !== 1'b1 || error !== 1'b0 || words_loaded !== 13'd2) begin
            errors++;
            $display("FAIL start_in_data_status: done=%b err=%b wl=%0d required 1 0 2",
                     done, error, words_loaded);
        end
        checks++;
        if (wr_addr.size() != 2) begin
            errors++;
            $display("FAIL start_in_data_count: got %0d required 2", wr_addr.size());
        end else begin
            checks++;
            if (wr_addr[0] !== 12'd0 || wr_data[0] !== 32'h2008_0005 ||
                wr_addr[1] !== 12'd1 || wr_data[1] !== 32'h0000_000C) begin
                errors++;
                $display("FAIL start_in_data_writes: %h:%h %h:%h required 000:20080005 001:0000000c",
                         wr_addr[0], wr_data[0], wr_addr[1], wr_data[1]);
            end
        end
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        byte_in    = 8'h00;
        byte_valid = 1'b0;
        test_reset();
        test_good_load();
        test_bad_csum();
        test_bad_len();
        test_random_valid();
        test_reset_midload();
        test_start_in_data();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Program-load initiator for the instruction memory's init port.
- Accepts a framed byte stream over a valid/ready handshake, for example from a UART receiver or a testbench host.
- Assembles big-endian 32-bit instruction words and drives init_mode, init_address, init_instruction and write_enable, one word per write.
- Reports completion, word count and frame/checksum errors so the top level can release the CPU from reset into run mode.

Parameters:
- ADDR_W, 12, word-address width of the instruction memory init port.
- MAX_WORDS, 4096, largest accepted word count; must be ≤ 2**ADDR_W.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a load; ignored while busy.
- byte_in  input  8  stream data byte.
- byte_valid  input  1  byte_in is valid.
- byte_ready  output  1  loader accepts byte_in this cycle; a transfer happens when byte_valid && byte_ready.
- init_mode  output  1  high while a load is in progress; connects to the memory's init_mode.
- init_address  output  ADDR_W  word index being written.
- init_instruction  output  32  assembled word.
- write_enable  output  1  one-cycle write strobe.
- busy  output  1  FSM is not in IDLE, DONE or ERROR.
- done  output  1  sticky; the last load completed with a good checksum.
- error  output  1  sticky; the last load failed on length or checksum.
- words_loaded  output  ADDR_W+1  number of words written in the current or last load.

Behaviour:
- Reset values: byte_ready 0, init_mode 0, init_address 0, init_instruction 0, write_enable 0, busy 0, done 0, error 0, words_loaded 0. FSM goes to IDLE. Reset mid-load abandons the frame immediately; the memory keeps any words already written.
- Frame format:
  - LEN: 2 bytes, word count N, big-endian.
  - Payload: 4*N bytes, each word big-endian (first byte goes to [31:24]).
  - CSUM: 1 byte, XOR of all 4*N payload bytes.
- FSM states: IDLE, LEN_HI, LEN_LO, DATA, WRITE, CSUM, DONE, ERROR.
  - IDLE/DONE/ERROR: on start → LEN_HI. This clears done, error, words_loaded, the byte counter and the checksum accumulator.
  - LEN_HI: on a transfer, latch N[15:8] → LEN_LO.
  - LEN_LO: on a transfer, latch N[7:0]. If N==0 or N>MAX_WORDS → ERROR; otherwise → DATA.
  - DATA: each transfer shifts the byte into the word register and XORs it into the checksum. On the 4th byte → WRITE.
  - WRITE: exactly one cycle. write_enable=1, init_address=words_loaded[ADDR_W-1:0], init_instruction=assembled word. Then words_loaded increments. If words_loaded (new value) == N → CSUM; otherwise → DATA.
  - CSUM: on a transfer, compare the byte with the accumulator. Match → DONE (done=1). Mismatch → ERROR (error=1).
- byte_ready is 1 in LEN_HI, LEN_LO, DATA and CSUM, and 0 in every other state. It depends only on state, never combinationally on byte_valid.
- init_mode is 1 in LEN_HI through CSUM and 0 in IDLE, DONE and ERROR. It falls in the same cycle that done or error rises.
- Latency: if the 4th byte of a word transfers on edge t, write_enable is high in the cycle after edge t. With byte_valid held high, the best-case rate is 5 cycles per word.
- Stalls: byte_valid low in any accepting state holds state indefinitely. There is no timeout.
- start is ignored while busy; it does not restart a load in progress.
- In DONE/ERROR, start restarts in the same way as from IDLE. Any simultaneous byte_valid is not consumed, because byte_ready is 0 on that cycle.
- Memory writes that occurred before a checksum error remain in the memory; error only flags the load as invalid.
- words_loaded saturates at its final value. MAX_WORDS words therefore fit because the counter is ADDR_W+1 bits wide.

Decomposition:
- Shared package, for example loader_pkg:
  - state enum.
  - frame constants LEN_BYTES=2, WORD_BYTES=4.
  - IMEM_BASE = 32'h00400000, for documentation and top-level use.
- One natural sub-module: word_assembler (shift register plus 2-bit byte counter plus XOR accumulator). It has a clear/enable interface, and the FSM stays in imem_loader.

Test Plan:
- Load N=2 with payload 20 08 00 05 / 00 00 00 0C and csum 0x21:
  - write_enable at addr 0 with 0x20080005, then at addr 1 with 0x0000000C.
  - done=1, error=0, words_loaded=2, init_mode falls.
- Same frame with csum 0x00:
  - both writes occur, then error=1 and done=0.
- LEN=0x0000, then separately LEN=0x1001:
  - ERROR immediately after the 2nd length byte, with no write_enable pulse.
- byte_valid toggled randomly (50%) across an N=3 frame:
  - identical writes and addresses to the continuous-valid run.
  - byte_ready is 0 in every WRITE cycle.
- rst asserted after 6 payload bytes of N=4:
  - exactly one write has occurred, to addr 0.
  - all outputs return to reset values on the next edge.
  - a new start then loads correctly from addr 0.
- start pulsed while in DATA:
  - no effect on state, counters or written data.
